// File: rtl/cpc_romsel_ctrl.sv
// CPC expansion-ROM board controller: decodes the upper-ROM select port, drives the device
// chip selects, and runs an unlock-protected EEPROM write sequence with a write-cycle wait.
module cpc_romsel_ctrl #(
    parameter int          BANK       = 0,
    parameter logic [7:0]  SLOT_MASK  = 8'hFF,
    parameter int          WE_CYCLES  = 2,
    parameter int          TWC_CYCLES = 40000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       A15,
    input  logic       A14,
    input  logic       A13,
    input  logic       A12,
    input  logic [7:0] D,
    input  logic       MREQ_B,
    input  logic       IOREQ_B,
    input  logic       WR_B,
    output logic [3:0] romcs_b,
    output logic       rom_a14,
    output logic       rom_we_b,
    output logic       romdis,
    output logic       busy
);

    localparam logic        BANK_BIT = (BANK != 0);
    localparam logic [15:0] WE_LAST  = 16'(WE_CYCLES - 1);
    localparam logic [15:0] TWC_LAST = 16'(TWC_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        UNLK1  = 3'd1,
        ARMED  = 3'd2,
        WPULSE = 3'd3,
        WAIT   = 3'd4
    } state_t;

    // Registered copies of the bus; every decode below works on these.
    logic       a15_q, a14_q, a13_q, a12_q;
    logic [7:0] d_q;
    logic       mreq_b_q, ioreq_b_q, wr_b_q;
    logic       io_wr_prev_q, mem_wr_prev_q;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  rom_sel_q, rom_sel_d;
    logic [7:0]  pend_q, pend_d;
    logic        pend_vld_q, pend_vld_d;

    logic [3:0] romcs_b_q, romcs_b_d;
    logic       rom_a14_q, rom_a14_d;
    logic       romdis_q, romdis_d;
    logic       rom_we_b_q, rom_we_b_d;
    logic       busy_q, busy_d;

    logic io_wr, mem_wr, io_stb, mem_stb, sel_stb, ctl_stb, hit, in_write;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            a15_q         <= 1'b0;
            a14_q         <= 1'b0;
            a13_q         <= 1'b0;
            a12_q         <= 1'b0;
            d_q           <= 8'h00;
            mreq_b_q      <= 1'b1;
            ioreq_b_q     <= 1'b1;
            wr_b_q        <= 1'b1;
            io_wr_prev_q  <= 1'b0;
            mem_wr_prev_q <= 1'b0;
        end else begin
            a15_q         <= A15;
            a14_q         <= A14;
            a13_q         <= A13;
            a12_q         <= A12;
            d_q           <= D;
            mreq_b_q      <= MREQ_B;
            ioreq_b_q     <= IOREQ_B;
            wr_b_q        <= WR_B;
            io_wr_prev_q  <= io_wr;
            mem_wr_prev_q <= mem_wr;
        end
    end

    assign io_wr   = !ioreq_b_q && !wr_b_q;
    assign mem_wr  = !mreq_b_q && !wr_b_q;
    assign io_stb  = io_wr && !io_wr_prev_q;
    // An I/O strobe in the same cycle wins; the memory write is simply lost.
    assign mem_stb = mem_wr && !mem_wr_prev_q && !io_stb;
    assign sel_stb = io_stb && !a13_q && a12_q;
    assign ctl_stb = io_stb && !a13_q && !a12_q;

    assign hit      = (rom_sel_q[7:4] == 4'd0) && (rom_sel_q[3] == BANK_BIT)
                      && SLOT_MASK[rom_sel_q[2:0]];
    assign in_write = (state_q == WPULSE) || (state_q == WAIT);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rom_sel_d  = rom_sel_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;

        unique case (state_q)
            IDLE: begin
                if (ctl_stb && d_q == 8'hA5) state_d = UNLK1;
            end
            UNLK1: begin
                if (ctl_stb) state_d = (d_q == 8'h5A) ? ARMED : IDLE;
            end
            ARMED: begin
                if (ctl_stb && d_q == 8'h00) begin
                    state_d = IDLE;
                end else if (mem_stb && a15_q && a14_q && hit) begin
                    state_d = WPULSE;
                    cnt_d   = 16'd0;
                end
            end
            WPULSE: begin
                if (cnt_q == WE_LAST) begin
                    state_d = WAIT;
                    cnt_d   = 16'd0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            WAIT: begin
                if (cnt_q == TWC_LAST) begin
                    state_d = ARMED;
                    cnt_d   = 16'd0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 16'd0;
            end
        endcase

        // Selection is frozen while a write is in flight so CS/A14 never move under it.
        if (sel_stb) begin
            if (in_write) begin
                pend_d     = d_q;
                pend_vld_d = 1'b1;
            end else begin
                rom_sel_d = d_q;
            end
        end

        if (state_q == WAIT && state_d == ARMED) begin
            if (sel_stb) begin
                rom_sel_d = d_q;
            end else if (pend_vld_q) begin
                rom_sel_d = pend_q;
            end
            pend_d     = 8'h00;
            pend_vld_d = 1'b0;
        end
    end

    always_comb begin
        rom_we_b_d = (state_d != WPULSE);
        busy_d     = (state_d == WPULSE) || (state_d == WAIT);
        romdis_d   = hit;
        rom_a14_d  = rom_sel_q[0];
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_cs
        assign romcs_b_d[gi] = !(hit && (rom_sel_q[2:1] == 2'(gi)));
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= IDLE;
            cnt_q      <= 16'd0;
            rom_sel_q  <= 8'h00;
            pend_q     <= 8'h00;
            pend_vld_q <= 1'b0;
            romcs_b_q  <= 4'hF;
            rom_a14_q  <= 1'b0;
            romdis_q   <= 1'b0;
            rom_we_b_q <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rom_sel_q  <= rom_sel_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            romcs_b_q  <= romcs_b_d;
            rom_a14_q  <= rom_a14_d;
            romdis_q   <= romdis_d;
            rom_we_b_q <= rom_we_b_d;
            busy_q     <= busy_d;
        end
    end

    assign romcs_b  = romcs_b_q;
    assign rom_a14  = rom_a14_q;
    assign romdis   = romdis_q;
    assign rom_we_b = rom_we_b_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_cpc_romsel_ctrl.sv
// Scoreboard bench for cpc_romsel_ctrl: two instances (full slot mask and slot 5 masked)
// share the bus; expected outputs are queued with a due cycle and checked on the falling edge.
module tb_cpc_romsel_ctrl;
    localparam int TWC = 40000;
    localparam logic [7:0] MASK0 = 8'hFF;
    localparam logic [7:0] MASK1 = 8'hDF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, a15, a14, a13, a12, mreq_b, ioreq_b, wr_b;
    logic [7:0] d;
    logic [3:0] cs0, cs1;
    logic       a14_0, a14_1, we0, we1, dis0, dis1, busy0, busy1;

    cpc_romsel_ctrl #(.BANK(0), .SLOT_MASK(MASK0), .WE_CYCLES(2), .TWC_CYCLES(TWC)) dut0 (
        .CLK(clk), .RESET(rst), .A15(a15), .A14(a14), .A13(a13), .A12(a12), .D(d),
        .MREQ_B(mreq_b), .IOREQ_B(ioreq_b), .WR_B(wr_b),
        .romcs_b(cs0), .rom_a14(a14_0), .rom_we_b(we0), .romdis(dis0), .busy(busy0)
    );

    cpc_romsel_ctrl #(.BANK(0), .SLOT_MASK(MASK1), .WE_CYCLES(2), .TWC_CYCLES(TWC)) dut1 (
        .CLK(clk), .RESET(rst), .A15(a15), .A14(a14), .A13(a13), .A12(a12), .D(d),
        .MREQ_B(mreq_b), .IOREQ_B(ioreq_b), .WR_B(wr_b),
        .romcs_b(cs1), .rom_a14(a14_1), .rom_we_b(we1), .romdis(dis1), .busy(busy1)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_total = 0;
    int n_bad   = 0;

    typedef struct {
        int         due;
        int         which;
        logic [7:0] vec;
        string      tag;
    } exp_t;
    exp_t sb_q[$];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        if (obs !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, expv);
        end else begin
            $display("ok   %s = %0h", tag, obs);
        end
    endtask

    // {romcs_b, rom_a14, romdis, rom_we_b, busy}
    function automatic logic [7:0] model_vec(input logic [7:0] sel, input logic [7:0] mask,
                                             input logic we, input logic bsy);
        logic       h;
        logic [3:0] cs;
        h  = (sel[7:4] == 4'd0) && !sel[3] && mask[sel[2:0]];
        cs = 4'hF;
        if (h) cs[sel[2:1]] = 1'b0;
        return {cs, sel[0], h, we, bsy};
    endfunction

    task automatic push_both(input int due, input logic [7:0] sel, input logic we,
                             input logic bsy, input string tag);
        exp_t e;
        e.due = due; e.which = 0; e.vec = model_vec(sel, MASK0, we, bsy); e.tag = tag;
        sb_q.push_back(e);
        e.which = 1; e.vec = model_vec(sel, MASK1, we, bsy);
        sb_q.push_back(e);
    endtask

    task automatic push_rst(input int due, input string tag);
        exp_t e;
        e.due = due; e.vec = {4'hF, 1'b0, 1'b0, 1'b1, 1'b0}; e.tag = tag;
        e.which = 0; sb_q.push_back(e);
        e.which = 1; sb_q.push_back(e);
    endtask

    always @(negedge clk) begin
        int         i;
        logic [7:0] obs;
        i = 0;
        while (i < sb_q.size()) begin
            if (sb_q[i].due == cyc) begin
                obs = (sb_q[i].which == 0) ? {cs0, a14_0, dis0, we0, busy0}
                                           : {cs1, a14_1, dis1, we1, busy1};
                check_val($sformatf("%s.dut%0d@%0d", sb_q[i].tag, sb_q[i].which, cyc),
                          32'(obs), 32'(sb_q[i].vec));
                sb_q.delete(i);
            end else begin
                i++;
            end
        end
    end

    task automatic io_write(input logic a13v, input logic a12v, input logic [7:0] dv);
        a13 = a13v; a12 = a12v; d = dv; ioreq_b = 1'b0; wr_b = 1'b0;
        @(negedge clk);
        ioreq_b = 1'b1; wr_b = 1'b1;
        @(negedge clk);
    endtask

    task automatic mem_write(input logic a15v, input logic a14v);
        a15 = a15v; a14 = a14v; mreq_b = 1'b0; wr_b = 1'b0;
        @(negedge clk);
        mreq_b = 1'b1; wr_b = 1'b1;
        @(negedge clk);
    endtask

    task automatic both_write(input logic [7:0] dv);
        a15 = 1'b1; a14 = 1'b1; a13 = 1'b0; a12 = 1'b0; d = dv;
        ioreq_b = 1'b0; mreq_b = 1'b0; wr_b = 1'b0;
        @(negedge clk);
        ioreq_b = 1'b1; mreq_b = 1'b1; wr_b = 1'b1;
        @(negedge clk);
    endtask

    task automatic sel_write(input logic [7:0] dv, input string tag);
        push_both(cyc + 3, dv, 1'b1, 1'b0, tag);
        io_write(1'b0, 1'b1, dv);
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    initial begin
        #(10 * 100000);
        $display("FAIL watchdog: cycle %0d reached time limit, want finish", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int t, tw, t2;
        rst = 1'b0; a15 = 1'b0; a14 = 1'b0; a13 = 1'b0; a12 = 1'b0; d = 8'h00;
        mreq_b = 1'b1; ioreq_b = 1'b1; wr_b = 1'b1;
        repeat (2) @(negedge clk);

        t = cyc;
        rst = 1'b1;
        push_rst(t + 1, "rst_a");
        push_rst(t + 2, "rst_b");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        push_both(t + 3, 8'h00, 1'b1, 1'b0, "post_rst");
        @(negedge clk);

        sel_write(8'h05, "sel05");
        sel_write(8'h0D, "sel0D");
        sel_write(8'h08, "sel08");
        sel_write(8'h02, "sel02");

        // Broken unlock sequence leaves the FSM idle.
        io_write(1'b0, 1'b0, 8'hA5);
        io_write(1'b0, 1'b0, 8'h33);
        io_write(1'b0, 1'b0, 8'h5A);
        t = cyc;
        push_both(t + 2, 8'h02, 1'b1, 1'b0, "nowr_a");
        push_both(t + 3, 8'h02, 1'b1, 1'b0, "nowr_b");
        push_both(t + 4, 8'h02, 1'b1, 1'b0, "nowr_c");
        mem_write(1'b1, 1'b1);

        io_write(1'b0, 1'b0, 8'hA5);
        io_write(1'b0, 1'b0, 8'h5A);

        t = cyc;
        push_both(t + 2, 8'h02, 1'b1, 1'b0, "prio_a");
        push_both(t + 3, 8'h02, 1'b1, 1'b0, "prio_b");
        both_write(8'h11);

        t = cyc;
        push_both(t + 2, 8'h02, 1'b1, 1'b0, "addr_miss");
        mem_write(1'b1, 1'b0);

        tw = cyc;
        push_both(tw + 2, 8'h02, 1'b0, 1'b1, "wpulse_0");
        push_both(tw + 3, 8'h02, 1'b0, 1'b1, "wpulse_1");
        push_both(tw + 4, 8'h02, 1'b1, 1'b1, "wait_0");
        push_both(tw + 3 + TWC, 8'h02, 1'b1, 1'b1, "wait_last");
        push_both(tw + 4 + TWC, 8'h02, 1'b1, 1'b0, "armed");
        push_both(tw + 5 + TWC, 8'h06, 1'b1, 1'b0, "pend_apply");
        mem_write(1'b1, 1'b1);

        wait_until(tw + 100);
        t = cyc;
        push_both(t + 5, 8'h02, 1'b1, 1'b1, "hold03");
        io_write(1'b0, 1'b1, 8'h03);
        t = cyc;
        push_both(t + 5, 8'h02, 1'b1, 1'b1, "hold06");
        io_write(1'b0, 1'b1, 8'h06);
        io_write(1'b0, 1'b0, 8'h00);

        wait_until(tw + TWC + 6);

        // Still armed after the wait; reset lands in the middle of the new pulse.
        t2 = cyc;
        push_both(t2 + 2, 8'h06, 1'b0, 1'b1, "wp_again");
        push_rst(t2 + 3, "rst_mid");
        mem_write(1'b1, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        push_both(t2 + 4, 8'h00, 1'b1, 1'b0, "rst_mid_post");
        @(negedge clk);

        t = cyc;
        push_both(t + 2, 8'h00, 1'b1, 1'b0, "idle_nowr_a");
        push_both(t + 3, 8'h00, 1'b1, 1'b0, "idle_nowr_b");
        mem_write(1'b1, 1'b1);

        repeat (5) @(negedge clk);
        check_val("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
